// File: rtl/instruction_memory_pkg.sv
// Shared constants for the instruction fetch memory: word width,
// default NOP encoding and the fault causes reported by the fetch port.
package instruction_memory_pkg;

  localparam int unsigned INSTR_W = 32;

  // addi x0, x0, 0
  localparam logic [INSTR_W-1:0] NOP_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_RANGE    = 2'd2
  } fault_cause_e;

endpackage

// File: rtl/instruction_memory_instr_ram.sv
// Instruction storage: one write port for program load, one synchronous
// read port for fetch. A read and a write to the same word in one cycle
// return the old contents. No reset: contents survive reset and flush.
module instr_ram
  import instruction_memory_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] widx,
  input  logic [INSTR_W-1:0]       wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] ridx,
  output logic [INSTR_W-1:0]       rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  // Write and registered read; non-blocking update gives read-before-write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
    if (re) begin
      rdata <= mem[ridx];
    end
  end

endmodule

// File: rtl/instruction_memory.sv
// Byte-addressed instruction fetch memory with a one-deep output register
// and valid/ready handshake on both the request and response side.
// Optional macro INSTR_MEM_FAULT_EN: misaligned or out-of-range fetches
// return NOP_WORD with rsp_fault=1; otherwise the index wraps modulo DEPTH.
module instruction_memory
  import instruction_memory_pkg::*;
#(
  parameter int unsigned       DEPTH      = 64,
  parameter int unsigned       ADDR_WIDTH = 32,
  parameter logic [INSTR_W-1:0] NOP_WORD  = NOP_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [INSTR_W-1:0]       rsp_instr,
  output logic                     rsp_fault,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  input  logic [INSTR_W-1:0]       load_data
);

  localparam int unsigned IW = $clog2(DEPTH);

  logic               valid_q;
  logic               nop_q;
  logic               accept;
  logic               fault_now;
  logic [IW-1:0]      rd_idx;
  logic [INSTR_W-1:0] rd_data;

  assign req_ready = (!valid_q || rsp_ready) && !flush;
  assign accept    = req_valid && req_ready;
  assign rd_idx    = req_addr[IW+1:2];

  // The RAM read register cannot be reset, so NOP_WORD is selected by a
  // resettable flag instead of being loaded into the data register.
  assign rsp_instr = nop_q ? NOP_WORD : rd_data;
  assign rsp_valid = valid_q;

`ifdef INSTR_MEM_FAULT_EN
  fault_cause_e cause;
  logic         fault_q;

  // Classify the incoming address; misalignment takes priority over range.
  always_comb begin
    cause = FAULT_NONE;
    if (req_addr[1:0] != 2'b00) begin
      cause = FAULT_MISALIGN;
    end else if ((req_addr >> (IW + 2)) != '0) begin
      cause = FAULT_RANGE;
    end
  end

  assign fault_now = (cause != FAULT_NONE);
  assign rsp_fault = fault_q;

  // Fault flag travels with the response it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (flush) begin
      fault_q <= 1'b0;
    end else if (accept) begin
      fault_q <= fault_now;
    end
  end
`else
  logic unused_addr;

  assign unused_addr = ^req_addr;
  assign fault_now   = 1'b0;
  assign rsp_fault   = 1'b0;
`endif

  // Output handshake register: load on accept, drop on take or flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      nop_q   <= 1'b1;
    end else if (flush) begin
      valid_q <= 1'b0;
      nop_q   <= 1'b1;
    end else if (accept) begin
      valid_q <= 1'b1;
      nop_q   <= fault_now;
    end else if (rsp_ready) begin
      valid_q <= 1'b0;
    end
  end

  instr_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (load_en),
    .widx (load_idx),
    .wdata(load_data),
    .re   (accept),
    .ridx (rd_idx),
    .rdata(rd_data)
  );

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_instruction_memory;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic        rsp_fault;
  logic        load_en;
  logic [5:0]  load_idx;
  logic [31:0] load_data;

  int n_chk  = 0;
  int n_fail = 0;

  instruction_memory dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr),
    .rsp_fault(rsp_fault),
    .load_en  (load_en),
    .load_idx (load_idx),
    .load_data(load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mem_m [DEPTH];
  bit          m_valid = 1'b0;
  bit          m_fault = 1'b0;
  bit          m_chk   = 1'b1;
  logic [31:0] m_instr = NOP;
  int unsigned ma;
  bit          mf;

  function automatic bit addr_faults(input int unsigned a);
`ifdef INSTR_MEM_FAULT_EN
    return (a % 4 != 0) || (a >= 4 * DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 1'b0;
      m_fault = 1'b0;
      m_instr = NOP;
      m_chk   = 1'b1;
    end else begin
      if (flush) begin
        m_valid = 1'b0;
        m_fault = 1'b0;
        m_instr = NOP;
        m_chk   = 1'b1;
      end else if (req_valid && (!m_valid || rsp_ready)) begin
        ma      = req_addr;
        mf      = addr_faults(ma);
        m_valid = 1'b1;
        m_fault = mf;
        m_instr = mf ? NOP : mem_m[(ma / 4) % DEPTH];
        m_chk   = 1'b1;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
        m_chk   = 1'b0;
      end
      if (load_en) mem_m[load_idx] = load_data;
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    chk("req_ready", 32'(req_ready), 32'((!m_valid || rsp_ready) && !flush));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    if (m_chk) begin
      chk("rsp_instr", rsp_instr, m_instr);
      chk("rsp_fault", 32'(rsp_fault), 32'(m_fault));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; req_valid = 0; req_addr = '0; rsp_ready = 1; load_en = 0;
  endtask

  logic [31:0] prog [6];
  logic [31:0] held;

  initial begin
    prog[0] = 32'h0010_0313; prog[1] = 32'h0000_0393; prog[2] = 32'h0003_0413;
    prog[3] = 32'h0073_0333; prog[4] = 32'h0004_0393; prog[5] = 32'hFF5F_F06F;
    reset = 1; idle(); rsp_ready = 0; load_idx = '0; load_data = '0;
    repeat (3) tick();
    reset = 0;
    tick();
    chk("reset_valid", 32'(rsp_valid), 32'd0);
    chk("reset_instr", rsp_instr, NOP);
    chk("reset_fault", 32'(rsp_fault), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd1);

    // Program load followed by a streaming fetch of six words.
    for (int unsigned i = 0; i < 6; i++) begin
      load_en = 1; load_idx = 6'(i); load_data = prog[i];
      tick();
    end
    load_en = 0;
    rsp_ready = 1;
    for (int unsigned i = 0; i < 6; i++) begin
      req_valid = 1; req_addr = 32'(4 * i);
      tick();
      chk("stream_valid", 32'(rsp_valid), 32'd1);
      chk("stream_instr", rsp_instr, prog[i]);
    end
    req_valid = 0;
    tick();
    chk("stream_drain", 32'(rsp_valid), 32'd0);

    // Backpressure: response held stable while consumer stalls.
    req_valid = 1; req_addr = 32'h8; rsp_ready = 0;
    tick();
    req_addr = 32'hC;
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_instr", rsp_instr, 32'h0003_0413);
      tick();
    end
    rsp_ready = 1;
    #1;
    chk("take_ready", 32'(req_ready), 32'd1);
    tick();
    chk("b2b_instr", rsp_instr, 32'h0073_0333);
    req_valid = 0;
    tick();

    // Read-before-write on a colliding load.
    req_valid = 1; req_addr = 32'h8;
    load_en = 1; load_idx = 6'd2; load_data = 32'hDEAD_BEEF;
    tick();
    chk("rbw_old", rsp_instr, 32'h0003_0413);
    load_en = 0;
    tick();
    chk("rbw_new", rsp_instr, 32'hDEAD_BEEF);
    req_valid = 0;
    tick();

    // Misaligned / out-of-range fetches.
`ifdef INSTR_MEM_FAULT_EN
    req_valid = 1; req_addr = 32'h6;
    tick();
    chk("mis_fault", 32'(rsp_fault), 32'd1);
    chk("mis_instr", rsp_instr, NOP);
    req_addr = 32'h100;
    tick();
    chk("oor_fault", 32'(rsp_fault), 32'd1);
    chk("oor_instr", rsp_instr, NOP);
`else
    req_valid = 1; req_addr = 32'h100;
    tick();
    chk("wrap_instr", rsp_instr, 32'h0010_0313);
    chk("wrap_fault", 32'(rsp_fault), 32'd0);
`endif
    req_valid = 0;
    tick();

    // Flush while a response is stalled.
    req_valid = 1; req_addr = 32'h4; rsp_ready = 0;
    tick();
    chk("pre_flush_valid", 32'(rsp_valid), 32'd1);
    flush = 1;
    #1;
    chk("flush_ready", 32'(req_ready), 32'd0);
    tick();
    chk("flush_valid", 32'(rsp_valid), 32'd0);
    chk("flush_instr", rsp_instr, NOP);
    flush = 0; req_valid = 0; rsp_ready = 1;
    tick();

    // Asynchronous reset drops a held response without a clock edge.
    req_valid = 1; req_addr = 32'h10; rsp_ready = 0;
    tick();
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    #2 reset = 1;
    #1;
    chk("async_rst_valid", 32'(rsp_valid), 32'd0);
    chk("async_rst_instr", rsp_instr, NOP);
    tick();
    reset = 0; req_valid = 0;
    repeat (2) tick();
    chk("post_rst_valid", 32'(rsp_valid), 32'd0);
    rsp_ready = 1;

    // Fill the whole memory with random contents, then random traffic.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      load_en = 1; load_idx = 6'(i); load_data = $urandom;
      tick();
    end
    load_en = 0;
    for (int unsigned c = 0; c < 3000; c++) begin
      flush     = ($urandom_range(15) == 0);
      req_valid = ($urandom_range(3) != 0);
      rsp_ready = ($urandom_range(2) != 0);
      load_en   = ($urandom_range(3) == 0);
      load_idx  = 6'($urandom_range(DEPTH - 1));
      load_data = $urandom;
      if ($urandom_range(9) < 7) req_addr = 32'(4 * $urandom_range(DEPTH - 1));
      else                       req_addr = $urandom;
      tick();
    end
    idle();
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
